// File: rtl/chunked_adder.sv
// Multi-cycle unsigned adder: processes CHUNK bits per clock.
// Optional saturation to WIDTH ones when the final carry is set.
module chunked_adder #(
    parameter int WIDTH = 10,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);

    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int LASTW  = WIDTH - (NCHUNK - 1) * CHUNK;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             sat_q;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] acc;

    int               base;
    logic [CHUNK-1:0] ach;
    logic [CHUNK-1:0] bch;
    logic [CHUNK:0]   csum;
    logic             last;
    logic             cout;
    logic [WIDTH-1:0] cmask;
    logic [WIDTH-1:0] cval;
    logic [WIDTH-1:0] acc_nx;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Bits past WIDTH fall off the shifts, so the short last chunk needs
    // no special masking; only its carry comes from a lower bit.
    always_comb begin
        base   = int'(idx) * CHUNK;
        ach    = CHUNK'(areg >> base);
        bch    = CHUNK'(breg >> base);
        csum   = {1'b0, ach} + {1'b0, bch} + (CHUNK+1)'(carry);
        last   = (idx == LAST);
        cout   = last ? csum[LASTW] : csum[CHUNK];
        cmask  = WIDTH'({CHUNK{1'b1}}) << base;
        cval   = WIDTH'(csum[CHUNK-1:0]) << base;
        acc_nx = (acc & ~cmask) | cval;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            sat_q <= 1'b0;
            areg  <= '0;
            breg  <= '0;
            acc   <= '0;
            sum   <= '0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        areg  <= a;
                        breg  <= b;
                        sat_q <= sat_en;
                        carry <= 1'b0;
                        idx   <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    acc   <= acc_nx;
                    carry <= cout;
                    if (last) begin
                        idx   <= '0;
                        ovf   <= cout;
                        state <= DONE;
                        if (sat_q && cout)
                            sum <= {1'b0, {WIDTH{1'b1}}};
                        else
                            sum <= {cout, acc_nx};
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: three parameterisations against
// a plain-arithmetic reference model.
module tb_chunked_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] in_valid = '0;
    logic [2:0] sat_en = '0;
    logic [2:0] out_ready = '0;
    logic [2:0] in_ready;
    logic [2:0] out_valid;
    logic [2:0] ovf;
    logic [9:0] a [3];
    logic [9:0] b [3];
    logic [10:0] sum0;
    logic [8:0]  sum1;
    logic [10:0] sum2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(10), .CHUNK(4)) u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .sat_en(sat_en[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum0), .ovf(ovf[0])
    );

    chunked_adder #(.WIDTH(8), .CHUNK(8)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1][7:0]), .b(b[1][7:0]), .sat_en(sat_en[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum1), .ovf(ovf[1])
    );

    chunked_adder #(.WIDTH(10), .CHUNK(3)) u2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a[2]), .b(b[2]), .sat_en(sat_en[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(sum2), .ovf(ovf[2])
    );

    function automatic int wof(input int k);
        return (k == 1) ? 8 : 10;
    endfunction

    function automatic int latof(input int k);
        return (k == 0) ? 3 : (k == 1) ? 1 : 4;
    endfunction

    function automatic logic [10:0] sumof(input int k);
        if (k == 0) return sum0;
        if (k == 1) return {2'b00, sum1};
        return sum2;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic scramble(input int k);
        a[k]        = 10'($urandom);
        b[k]        = 10'($urandom);
        in_valid[k] = 1'($urandom);
        sat_en[k]   = 1'($urandom);
    endtask

    task automatic txn(input int k, input logic [9:0] av, input logic [9:0] bv,
                       input logic s, input int hold);
        longint      full;
        longint      maxv;
        logic [10:0] es;
        logic        eo;
        int          lat;
        maxv = (longint'(1) << wof(k)) - 1;
        full = longint'(av) + longint'(bv);
        eo   = (full > maxv);
        es   = (s && eo) ? 11'(maxv) : 11'(full);
        a[k] = av;
        b[k] = bv;
        sat_en[k]   = s;
        in_valid[k] = 1'b1;
        check("in_ready_before", 32'(in_ready[k]), 32'd1);
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        lat = 0;
        while (!out_valid[k] && lat < 16) begin
            scramble(k);
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(latof(k)));
        check("sum", 32'(sumof(k)), 32'(es));
        check("ovf", 32'(ovf[k]), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            scramble(k);
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid[k]), 32'd1);
            check("hold_ready", 32'(in_ready[k]), 32'd0);
            check("hold_sum", 32'(sumof(k)), 32'(es));
            check("hold_ovf", 32'(ovf[k]), 32'(eo));
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[k] = 1'b0;
        check("idle_ready", 32'(in_ready[k]), 32'd1);
        check("idle_valid", 32'(out_valid[k]), 32'd0);
        check("idle_retain", 32'(sumof(k)), 32'(es));
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            a[k] = '0;
            b[k] = '0;
        end
        #12;
        check("rst_sum", 32'(sum0), 32'd0);
        check("rst_ovf", 32'(ovf[0]), 32'd0);
        check("rst_valid", 32'(out_valid[0]), 32'd0);
        check("rst_ready", 32'(in_ready[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        txn(0, 10'h3FF, 10'h001, 1'b0, 0);
        txn(0, 10'h3FF, 10'h001, 1'b1, 0);
        txn(0, 10'h155, 10'h0AA, 1'b1, 0);
        txn(0, 10'h155, 10'h2AA, 1'b1, 0);
        txn(0, 10'h2F0, 10'h1A5, 1'b0, 5);

        // abort mid-operation with a non-zero result still on the outputs
        a[0] = 10'h123;
        b[0] = 10'h0FF;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_sum", 32'(sum0), 32'd0);
        check("abort_ovf", 32'(ovf[0]), 32'd0);
        check("abort_valid", 32'(out_valid[0]), 32'd0);
        check("abort_ready", 32'(in_ready[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_result", 32'(out_valid[0]), 32'd0);
        end
        txn(0, 10'h200, 10'h200, 1'b0, 0);

        txn(1, 10'h0FF, 10'h0FF, 1'b0, 0);
        txn(1, 10'h0FF, 10'h0FF, 1'b1, 0);
        for (int i = 0; i < 20; i++)
            txn(1, 10'($urandom_range(255)), 10'($urandom_range(255)),
                1'($urandom), 0);

        txn(2, 10'h200, 10'h200, 1'b0, 0);
        for (int i = 0; i < 1000; i++)
            txn(2, 10'($urandom), 10'($urandom), 1'($urandom), 0);

        for (int i = 0; i < 100; i++)
            txn(0, 10'($urandom), 10'($urandom), 1'($urandom),
                int'($urandom_range(2)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
